watermark_embed_stream: RTL and testbench

WATERMARK_EMBED_STREAM -- requirements
Module: watermark_embed_stream

---
 rtl/wm_pkg.sv | 35 +++
 rtl/watermark_embed_stream_if.sv | 26 ++
 rtl/wm_scale_round.sv | 38 +++
 rtl/watermark_embed_stream.sv | 147 ++++++++++++++
 tb/tb_watermark_embed_stream.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wm_pkg.sv
// Shared widths, mode encoding and the saturation classifier for the
// watermark embed/extract stream.
package wm_pkg;

  localparam int unsigned WM_DATA_W    = 32;
  localparam int unsigned WM_ALPHA_W   = 16;
  localparam int unsigned WM_FRAC_W    = 8;
  localparam int unsigned WM_BLOCK_LEN = 4096;
  localparam int unsigned WM_SAT_W     = 128;

  typedef enum logic {
    WM_EMBED   = 1'b0,
    WM_EXTRACT = 1'b1
  } wm_mode_e;

  typedef enum logic [1:0] {
    WM_SAT_NONE = 2'd0,
    WM_SAT_HI   = 2'd1,
    WM_SAT_LO   = 2'd2
  } wm_sat_e;

  // Classifies a wide signed value against the signed range of width w;
  // callers substitute the clip value for their own width.
  function automatic wm_sat_e saturate(input logic signed [WM_SAT_W-1:0] v,
                                       input int unsigned w);
    logic signed [WM_SAT_W-1:0] hi;
    logic signed [WM_SAT_W-1:0] lo;
    hi = $signed((WM_SAT_W'(1) << (w - 1)) - WM_SAT_W'(1));
    lo = ~hi;
    if (v > hi) return WM_SAT_HI;
    if (v < lo) return WM_SAT_LO;
    return WM_SAT_NONE;
  endfunction

endpackage

// File: rtl/watermark_embed_stream_if.sv
// Input/output stream handshake bundle of the watermark block.
interface watermark_embed_stream_if
  import wm_pkg::*;
#(
  parameter int unsigned DATA_W = WM_DATA_W
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_host;
  logic signed [DATA_W-1:0] in_mark;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;
  logic                     out_sat;

  modport slave (
    input  in_valid, in_host, in_mark, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sat
  );

  modport master (
    output in_valid, in_host, in_mark, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sat
  );
endinterface

// File: rtl/wm_scale_round.sv
// Registered alpha*mark product with round-half-up and arithmetic shift
// back to integer scale.
module wm_scale_round
  import wm_pkg::*;
#(
  parameter int unsigned DATA_W  = WM_DATA_W,
  parameter int unsigned ALPHA_W = WM_ALPHA_W,
  parameter int unsigned FRAC_W  = WM_FRAC_W,
  localparam int unsigned PROD_W = DATA_W + ALPHA_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [ALPHA_W-1:0]       alpha,
  input  logic signed [DATA_W-1:0] mark,
  output logic signed [PROD_W-1:0] scaled
);

  localparam logic signed [PROD_W-1:0] RND = PROD_W'(1) << (FRAC_W - 1);

  logic signed [PROD_W-1:0] alpha_x;
  logic signed [PROD_W-1:0] mark_x;
  logic signed [PROD_W-1:0] prod_q;

  assign alpha_x = {{(PROD_W - ALPHA_W){1'b0}}, alpha};
  assign mark_x  = {{(PROD_W - DATA_W){mark[DATA_W-1]}}, mark};

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
    end else if (en) begin
      prod_q <= alpha_x * mark_x;
    end
  end

  assign scaled = (prod_q + RND) >>> FRAC_W;

endmodule

// File: rtl/watermark_embed_stream.sv
// Three-stage embed/extract pipeline (capture, multiply, round/add/saturate)
// with frame beat counting, per-frame config latch and saturation counting.
module watermark_embed_stream
  import wm_pkg::*;
#(
  parameter int unsigned DATA_W    = WM_DATA_W,
  parameter int unsigned ALPHA_W   = WM_ALPHA_W,
  parameter int unsigned FRAC_W    = WM_FRAC_W,
  parameter int unsigned BLOCK_LEN = WM_BLOCK_LEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ALPHA_W-1:0]        cfg_alpha,
  input  logic                      cfg_mode,
  watermark_embed_stream_if.slave   bus,
  output logic [15:0]               sat_cnt,
  output logic                      frame_done
);

  localparam int unsigned CNT_W  = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int unsigned PROD_W = DATA_W + ALPHA_W + 1;
  localparam int unsigned SUM_W  = PROD_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

  logic en, in_fire, out_fire;
  logic [CNT_W-1:0]   idx_q;
  logic [ALPHA_W-1:0] alpha_q, beat_alpha;
  wm_mode_e           mode_q, beat_mode;

  logic                     s1_valid, s1_first, s1_last;
  wm_mode_e                 s1_mode;
  logic [ALPHA_W-1:0]       s1_alpha;
  logic signed [DATA_W-1:0] s1_host, s1_mark;

  logic                     s2_valid, s2_first, s2_last;
  wm_mode_e                 s2_mode;
  logic signed [DATA_W-1:0] s2_host, s2_mark;
  logic signed [PROD_W-1:0] scaled;

  logic                       out_first_q;
  logic signed [SUM_W-1:0]    host_x, mark_x, scaled_x, sum;
  logic signed [WM_SAT_W-1:0] sum_w;
  wm_sat_e                    sat_kind;
  logic signed [DATA_W-1:0]   res;

  assign en          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;
  assign in_fire     = bus.in_valid && en;
  assign out_fire    = bus.out_valid && bus.out_ready;

  // Beat 0 uses the live config; later beats of the frame use the copy
  // latched when beat 0 was accepted.
  assign beat_alpha = (idx_q == '0) ? cfg_alpha : alpha_q;
  assign beat_mode  = (idx_q == '0) ? wm_mode_e'(cfg_mode) : mode_q;

  wm_scale_round #(
    .DATA_W  (DATA_W),
    .ALPHA_W (ALPHA_W),
    .FRAC_W  (FRAC_W)
  ) u_scale (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .alpha  (s1_alpha),
    .mark   (s1_mark),
    .scaled (scaled)
  );

  always_comb begin
    host_x   = {{(SUM_W - DATA_W){s2_host[DATA_W-1]}}, s2_host};
    mark_x   = {{(SUM_W - DATA_W){s2_mark[DATA_W-1]}}, s2_mark};
    scaled_x = {scaled[PROD_W-1], scaled};
    sum      = (s2_mode == WM_EXTRACT) ? (mark_x - host_x) : (host_x + scaled_x);
    sum_w    = {{(WM_SAT_W - SUM_W){sum[SUM_W-1]}}, sum};
    sat_kind = saturate(sum_w, DATA_W);
    case (sat_kind)
      WM_SAT_HI: res = {1'b0, {(DATA_W - 1){1'b1}}};
      WM_SAT_LO: res = {1'b1, {(DATA_W - 1){1'b0}}};
      default:   res = sum[DATA_W-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      alpha_q      <= '0;
      mode_q       <= WM_EMBED;
      s1_valid     <= 1'b0;
      s1_first     <= 1'b0;
      s1_last      <= 1'b0;
      s1_mode      <= WM_EMBED;
      s1_alpha     <= '0;
      s1_host      <= '0;
      s1_mark      <= '0;
      s2_valid     <= 1'b0;
      s2_first     <= 1'b0;
      s2_last      <= 1'b0;
      s2_mode      <= WM_EMBED;
      s2_host      <= '0;
      s2_mark      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_sat   <= 1'b0;
      out_first_q  <= 1'b0;
      sat_cnt      <= '0;
      frame_done   <= 1'b0;
    end else begin
      if (in_fire) begin
        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + CNT_W'(1);
        if (idx_q == '0) begin
          alpha_q <= cfg_alpha;
          mode_q  <= wm_mode_e'(cfg_mode);
        end
      end
      if (en) begin
        s1_valid      <= bus.in_valid;
        s1_first      <= bus.in_valid && (idx_q == '0);
        s1_last       <= bus.in_valid && (idx_q == LAST_IDX);
        s1_mode       <= beat_mode;
        s1_alpha      <= beat_alpha;
        s1_host       <= bus.in_host;
        s1_mark       <= bus.in_mark;
        s2_valid      <= s1_valid;
        s2_first      <= s1_first;
        s2_last       <= s1_last;
        s2_mode       <= s1_mode;
        s2_host       <= s1_host;
        s2_mark       <= s1_mark;
        bus.out_valid <= s2_valid;
        bus.out_data  <= res;
        bus.out_last  <= s2_last;
        bus.out_sat   <= (sat_kind != WM_SAT_NONE);
        out_first_q   <= s2_first;
      end
      if (out_fire) begin
        if (out_first_q) begin
          sat_cnt <= {15'd0, bus.out_sat};
        end else if (bus.out_sat && (sat_cnt != 16'hFFFF)) begin
          sat_cnt <= sat_cnt + 16'd1;
        end
      end
      frame_done <= out_fire && bus.out_last;
    end
  end

endmodule

// File: tb/tb_watermark_embed_stream.sv
// Bench for watermark_embed_stream: fixed vectors, hand-written frame
// sequences and randomized traffic checked against a queue-based model.
module tb_watermark_embed_stream;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int FW = 8;
  localparam int BL = 8;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -MAXV - 64'sd1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cfg_alpha;
  logic          cfg_mode;
  logic [15:0]   sat_cnt;
  logic          frame_done;

  watermark_embed_stream_if #(.DATA_W(DW)) bus ();

  watermark_embed_stream #(
    .DATA_W    (DW),
    .ALPHA_W   (AW),
    .FRAC_W    (FW),
    .BLOCK_LEN (BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_alpha  (cfg_alpha),
    .cfg_mode   (cfg_mode),
    .bus        (bus),
    .sat_cnt    (sat_cnt),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int data;
    bit last;
    bit sat;
    bit first;
  } exp_t;

  exp_t q[$];
  int   m_idx = 0;
  int   m_alpha = 0;
  bit   m_mode = 0;
  int   m_sat = 0;
  bit   m_fd = 0;
  bit   mon_en = 0;
  int   out_count = 0;
  int   fd_count = 0;
  int   out_log[$];
  bit   last_log[$];

  function automatic exp_t model(input bit mode, input longint alpha,
                                 input longint host, input longint mark);
    longint v;
    exp_t   e;
    if (mode) v = mark - host;
    else      v = host + ((alpha * mark + (64'sd1 <<< (FW - 1))) >>> FW);
    e.sat = 1'b0;
    if (v > MAXV) begin v = MAXV; e.sat = 1'b1; end
    else if (v < MINV) begin v = MINV; e.sat = 1'b1; end
    e.data  = int'(v);
    e.last  = 1'b0;
    e.first = 1'b0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("sat_cnt", sat_cnt, m_sat);
      check("frame_done", frame_done, m_fd);
      if (frame_done === 1'b1) fd_count++;
      m_fd = 1'b0;
      if (rst) begin
        q.delete();
        m_idx = 0; m_alpha = 0; m_mode = 0; m_sat = 0;
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out: got data %0d with no beat expected", bus.out_data);
          end else begin
            e = q.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_last", bus.out_last, e.last);
            check("out_sat", bus.out_sat, e.sat);
            out_log.push_back(bus.out_data);
            last_log.push_back(bus.out_last);
            out_count++;
            if (e.first) m_sat = e.sat;
            else if (e.sat && m_sat < 65535) m_sat++;
            m_fd = e.last;
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          if (m_idx == 0) begin m_alpha = cfg_alpha; m_mode = cfg_mode; end
          e = model(m_mode, m_alpha, longint'(bus.in_host), longint'(bus.in_mark));
          e.first = (m_idx == 0);
          e.last  = (m_idx == BL - 1);
          q.push_back(e);
          m_idx = (m_idx + 1) % BL;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int ready_mode = 0;   // 0: always ready, 1: 1010 toggle, 2: random
  int gap_pct = 0;
  bit fixed_data = 0;
  int fixed_host = 0;
  int fixed_mark = 0;
  bit rand_cfg = 0;
  int chg_at = -1;
  int chg_alpha = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    out_log.delete();
    last_log.delete();
    out_count = 0;
    fd_count = 0;
  endtask

  function automatic int rnd_val();
    case ($urandom_range(7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return int'($urandom_range(2000)) - 1000;
      default: return int'($urandom);
    endcase
  endfunction

  task automatic stream(input int n, input bit drain);
    int sent = 0;
    int cyc = 0;
    int max_cyc = n * 20 + 50;
    bit pend = 0;
    bit took;
    while ((sent < n || (drain && q.size() != 0)) && cyc < max_cyc) begin
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = (cyc % 2 == 0);
        default: bus.out_ready = ($urandom_range(9) < 7);
      endcase
      if (rand_cfg && $urandom_range(9) == 0) begin
        cfg_alpha = AW'($urandom_range(65535));
        cfg_mode  = 1'($urandom_range(1));
      end
      if (sent < n) begin
        if (sent == chg_at) cfg_alpha = AW'(chg_alpha);
        if (!pend) begin
          bus.in_host = fixed_data ? fixed_host : rnd_val();
          bus.in_mark = fixed_data ? fixed_mark : rnd_val();
          pend = 1'b1;
        end
        bus.in_valid = ($urandom_range(99) >= gap_pct);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      tick();
      if (took) begin sent++; pend = 1'b0; end
      cyc++;
    end
    bus.in_valid = 1'b0;
    if (cyc >= max_cyc) begin
      checks++; errors++;
      $display("FAIL stream_timeout: sent %0d of %0d, %0d beats outstanding", sent, n, q.size());
    end
  endtask

  // ---------------- single-beat vector table ----------------
  typedef struct {
    string name;
    bit    mode;
    int    alpha;
    int    host;
    int    mark;
    int    exp_data;
    bit    exp_sat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"embed_half",   1'b0, 32'h0080, 100,           7,            104,           1'b0};
    vecs[1] = '{"embed_sat_hi", 1'b0, 32'hFF00, 32'h7FFFFF00,  1000,         32'h7FFFFFFF,  1'b1};
    vecs[2] = '{"extract",      1'b1, 32'h1234, -50,           30,           80,            1'b0};
    vecs[3] = '{"embed_neg",    1'b0, 32'h0100, -10,           -5,           -15,           1'b0};
    vecs[4] = '{"embed_round",  1'b0, 32'h0080, 0,             -3,           -1,            1'b0};
    vecs[5] = '{"extract_lo",   1'b1, 32'h0000, 32'h7FFFFFFF,  -10,          32'h80000000,  1'b1};
    vecs[6] = '{"extract_hi",   1'b1, 32'hFFFF, 32'h80000000,  32'h7FFFFFFF, 32'h7FFFFFFF,  1'b1};
    vecs[7] = '{"embed_sat_lo", 1'b0, 32'hFFFF, 32'h80000000,  32'h80000000, 32'h80000000,  1'b1};

    rst = 1'b1;
    cfg_alpha = '0;
    cfg_mode = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_host = '0;
    bus.in_mark = '0;
    bus.out_ready = 1'b1;
    do_reset();
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_out_last", bus.out_last, 0);
    check("reset_out_sat", bus.out_sat, 0);
    check("reset_sat_cnt", sat_cnt, 0);
    check("reset_frame_done", frame_done, 0);
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_reset();
      clear_logs();
      cfg_alpha = AW'(vecs[i].alpha);
      cfg_mode = vecs[i].mode;
      bus.in_host = vecs[i].host;
      bus.in_mark = vecs[i].mark;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check({vecs[i].name, "_in_ready"}, bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      check({vecs[i].name, "_lat_c1"}, bus.out_valid, 0);
      tick();
      check({vecs[i].name, "_lat_c2"}, bus.out_valid, 0);
      tick();
      check({vecs[i].name, "_lat_c3"}, bus.out_valid, 1);
      check({vecs[i].name, "_data"}, bus.out_data, vecs[i].exp_data);
      check({vecs[i].name, "_sat"}, bus.out_sat, vecs[i].exp_sat);
      check({vecs[i].name, "_last"}, bus.out_last, 0);
      tick();
      check({vecs[i].name, "_sat_cnt"}, sat_cnt, vecs[i].exp_sat);
    end

    // Two abutting frames with output ready toggling 1,0,1,0.
    do_reset();
    clear_logs();
    cfg_alpha = 16'h0180;
    cfg_mode = 1'b0;
    ready_mode = 1;
    stream(16, 1'b1);
    tick();
    tick();
    check("bp_out_count", out_count, 16);
    check("bp_last7", last_log[7], 1);
    check("bp_last15", last_log[15], 1);
    check("bp_last6", last_log[6], 0);
    check("bp_frame_done_pulses", fd_count, 2);

    // Alpha changes mid-frame: beats 3..7 keep the latched value.
    do_reset();
    clear_logs();
    ready_mode = 0;
    fixed_data = 1'b1;
    fixed_host = 0;
    fixed_mark = 256;
    cfg_alpha = 16'h0040;
    chg_at = 3;
    chg_alpha = 16'h0300;
    stream(16, 1'b1);
    chg_at = -1;
    check("alpha_out_count", out_count, 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("alpha_beat%0d", i), out_log[i], (i < 8) ? 32'h40 : 32'h300);

    // Reset with three beats in flight; next frame restarts at beat 0.
    do_reset();
    clear_logs();
    cfg_alpha = 16'h0040;
    stream(6, 1'b0);
    rst = 1'b1;
    tick();
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_out_count", out_count, 3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", bus.in_ready, 1);
    tick();
    clear_logs();
    cfg_alpha = 16'h0300;
    stream(8, 1'b1);
    check("rst_restart_count", out_count, 8);
    check("rst_restart_beat0", out_log[0], 32'h300);
    check("rst_restart_beat7", out_log[7], 32'h300);
    check("rst_restart_last6", last_log[6], 0);
    check("rst_restart_last7", last_log[7], 1);

    // Randomized traffic, config churn and backpressure.
    do_reset();
    clear_logs();
    fixed_data = 1'b0;
    rand_cfg = 1'b1;
    ready_mode = 2;
    gap_pct = 20;
    stream(320, 1'b1);
    check("rand_out_count", out_count, 320);

    tick();
    tick();
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
